// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: {L,R} sample FIFO feeding a 32-sclk-per-frame serialiser.
// The bit clock is divided from audio_clk; the FIFO is popped only at frame start.
module audio_i2s_tx #(
    parameter int unsigned SCLK_HALF = 4,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                     audio_clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [15:0]              sample_l,
    input  logic [15:0]              sample_r,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    input  logic                     underrun_clr,
    output logic                     i2s_sclk,
    output logic                     i2s_lrclk,
    output logic                     i2s_sda
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    localparam logic [DW-1:0] DivMax  = DW'(SCLK_HALF - 1);
    localparam logic [LW-1:0] LvlFull = LW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [4:0]      bit_q, bit_d;
    logic            sclk_q, sclk_d;
    logic            lrclk_q, lrclk_d;
    logic            sda_q, sda_d;
    logic [31:0]     shift_q, shift_d;
    logic            underrun_q, underrun_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     mem_q [DEPTH];

    logic push;
    logic pop;
    logic urun_set;

    assign sample_ready = (level_q != LvlFull);
    assign push         = sample_valid && sample_ready;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        lrclk_d  = lrclk_q;
        sda_d    = sda_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        urun_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                div_d   = '0;
                bit_d   = 5'd31;
                sclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sda_d   = 1'b0;
                if (enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (div_q == DivMax) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        bit_d = bit_q + 5'd1;
                        // Frame boundary: the only point where enable is honoured and the FIFO pops
                        if (bit_q == 5'd31) begin
                            if (!enable) begin
                                state_d = StIdle;
                                bit_d   = 5'd31;
                                lrclk_d = 1'b0;
                                sda_d   = 1'b0;
                            end else if (level_q != '0) begin
                                pop     = 1'b1;
                                shift_d = mem_q[rd_ptr_q];
                            end else begin
                                shift_d  = '0;
                                urun_set = 1'b1;
                            end
                        end
                        if (state_d == StRun) begin
                            sda_d   = shift_d[5'd31 - bit_d];
                            lrclk_d = (bit_d >= 5'd15) && (bit_d <= 5'd30);
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
        // A set in the same cycle as a clear takes priority
        underrun_d = urun_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
    end

    always_ff @(posedge audio_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= 5'd31;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sda_q      <= 1'b0;
            shift_q    <= '0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            lrclk_q    <= lrclk_d;
            sda_q      <= sda_d;
            shift_q    <= shift_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live
    always_ff @(posedge audio_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sample_l, sample_r};
        end
    end

    assign fifo_level = level_q;
    assign underrun   = underrun_q;
    assign i2s_sclk   = sclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sda    = sda_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: frame format, FIFO fill/drain, underrun, enable drop, reset.
module tb_audio_i2s_tx;

    localparam int SCLK_HALF = 4;
    localparam int DEPTH     = 4;

    logic        audio_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        sample_ready;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic        i2s_sclk;
    logic        i2s_lrclk;
    logic        i2s_sda;

    int   passed = 0;
    int   total = 0;
    int   glitches = 0;
    int   timeouts = 0;
    logic fell = 1'b0;

    audio_i2s_tx #(
        .SCLK_HALF(SCLK_HALF),
        .DEPTH    (DEPTH)
    ) u_dut (
        .audio_clk   (audio_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .underrun_clr(underrun_clr),
        .i2s_sclk    (i2s_sclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sda     (i2s_sda)
    );

    always #5 audio_clk = ~audio_clk;

    // One clock; also notes sclk falls and any data/WS change on an sclk rise
    task automatic tick();
        logic ps, pl, pd;
        ps = i2s_sclk;
        pl = i2s_lrclk;
        pd = i2s_sda;
        @(posedge audio_clk);
        #1;
        fell = ps && !i2s_sclk;
        if (!ps && i2s_sclk && (i2s_lrclk !== pl || i2s_sda !== pd)) glitches++;
    endtask

    task automatic wait_fall();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fell && n < 200);
        if (!fell) timeouts++;
    endtask

    // Called at a frame-start fall; ends at the fall carrying bit 31
    task automatic capture_frame(input int drop_at, output logic [31:0] d,
                                 output logic [31:0] lr);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) wait_fall();
            d[31-k]  = i2s_sda;
            lr[31-k] = i2s_lrclk;
            if (k == drop_at) enable = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        if (i2s_sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", i2s_sclk);
        else passed++;
        total++;
        if (i2s_lrclk !== 1'b0) $display("FAIL reset_lrclk: got %b want 0", i2s_lrclk);
        else passed++;
        total++;
        if (i2s_sda !== 1'b0) $display("FAIL reset_sda: got %b want 0", i2s_sda);
        else passed++;
        total++;
        if (sample_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", sample_ready);
        else passed++;
        total++;
        if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level);
        else passed++;
        total++;
        if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun);
        else passed++;
        total++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        logic [31:0] d, lr;
        int rise_at, fall_at;
        sample_l     = 16'hA5C3;
        sample_r     = 16'h1234;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        sample_l     = 16'hFFFF;
        sample_r     = 16'hFFFF;
        if (fifo_level !== 3'd1) $display("FAIL push_level: got %0d want 1", fifo_level);
        else passed++;
        total++;
        enable = 1'b1;
        tick();
        rise_at = 0;
        fall_at = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (rise_at == 0 && i2s_sclk) rise_at = c;
            if (fell) begin
                fall_at = c;
                break;
            end
        end
        if (rise_at != 4) $display("FAIL first_rise: got cycle %0d want 4", rise_at);
        else passed++;
        total++;
        if (fall_at != 8) $display("FAIL first_fall: got cycle %0d want 8", fall_at);
        else passed++;
        total++;
        capture_frame(-1, d, lr);
        if (d !== 32'hA5C31234) $display("FAIL frame_data: got %h want a5c31234", d);
        else passed++;
        total++;
        if (lr !== 32'h0001FFFE) $display("FAIL frame_lrclk: got %h want 0001fffe", lr);
        else passed++;
        total++;
        if (underrun !== 1'b0) $display("FAIL frame_underrun: got %b want 0", underrun);
        else passed++;
        total++;
        enable = 1'b0;
        wait_fall();
        repeat (20) tick();
        if ({i2s_sclk, i2s_lrclk, i2s_sda} !== 3'b000)
            $display("FAIL idle_outputs: got %b want 000", {i2s_sclk, i2s_lrclk, i2s_sda});
        else passed++;
        total++;
        if (underrun !== 1'b0) $display("FAIL idle_underrun: got %b want 0", underrun);
        else passed++;
        total++;
    endtask

    task automatic test_underrun();
        logic [31:0] d, lr;
        enable = 1'b1;
        wait_fall();
        if (underrun !== 1'b1) $display("FAIL underrun_set: got %b want 1", underrun);
        else passed++;
        total++;
        capture_frame(-1, d, lr);
        if (d !== 32'h0) $display("FAIL underrun_data: got %h want 00000000", d);
        else passed++;
        total++;
        if (lr !== 32'h0001FFFE) $display("FAIL underrun_lrclk: got %h want 0001fffe", lr);
        else passed++;
        total++;
        underrun_clr = 1'b1;
        tick();
        if (underrun !== 1'b0) $display("FAIL underrun_clr: got %b want 0", underrun);
        else passed++;
        total++;
        // Clear still held when the next empty frame starts: the set must win
        wait_fall();
        underrun_clr = 1'b0;
        if (underrun !== 1'b1) $display("FAIL underrun_set_wins: got %b want 1", underrun);
        else passed++;
        total++;
        enable = 1'b0;
        repeat (32) wait_fall();
        if ({i2s_sclk, i2s_lrclk, i2s_sda} !== 3'b000)
            $display("FAIL underrun_idle: got %b want 000", {i2s_sclk, i2s_lrclk, i2s_sda});
        else passed++;
        total++;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        if (underrun !== 1'b0) $display("FAIL underrun_clr_idle: got %b want 0", underrun);
        else passed++;
        total++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pairs [5];
        logic [31:0] d, lr;
        pairs[0] = 32'h80017FFE;
        pairs[1] = 32'h0F0FF0F0;
        pairs[2] = 32'h13579BDF;
        pairs[3] = 32'hFFFFFFFF;
        pairs[4] = 32'h22224444;
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_l = pairs[i][31:16];
            sample_r = pairs[i][15:0];
            if (sample_ready !== (i < 4))
                $display("FAIL b2b_ready_%0d: got %b want %b", i, sample_ready, (i < 4));
            else passed++;
            total++;
            tick();
        end
        sample_valid = 1'b0;
        sample_l     = 16'h0BAD;
        sample_r     = 16'h0BAD;
        tick();
        if (fifo_level !== 3'd4) $display("FAIL b2b_level_full: got %0d want 4", fifo_level);
        else passed++;
        total++;
        if (sample_ready !== 1'b0) $display("FAIL b2b_ready_full: got %b want 0", sample_ready);
        else passed++;
        total++;
        enable = 1'b1;
        wait_fall();
        if (fifo_level !== 3'd3) $display("FAIL b2b_level_pop: got %0d want 3", fifo_level);
        else passed++;
        total++;
        if (sample_ready !== 1'b1) $display("FAIL b2b_ready_pop: got %b want 1", sample_ready);
        else passed++;
        total++;
        for (int f = 0; f < 3; f++) begin
            capture_frame(-1, d, lr);
            if (d !== pairs[f]) $display("FAIL b2b_frame_%0d: got %h want %h", f, d, pairs[f]);
            else passed++;
            total++;
            wait_fall();
        end
        if (fifo_level !== 3'd0) $display("FAIL b2b_level_drain: got %0d want 0", fifo_level);
        else passed++;
        total++;
    endtask

    // Entered at the frame start holding FFFF/FFFF
    task automatic test_enable_drop();
        logic [31:0] d, lr;
        capture_frame(10, d, lr);
        if (d !== 32'hFFFFFFFF) $display("FAIL drop_data: got %h want ffffffff", d);
        else passed++;
        total++;
        if (lr !== 32'h0001FFFE) $display("FAIL drop_lrclk: got %h want 0001fffe", lr);
        else passed++;
        total++;
        sample_l     = 16'h5555;
        sample_r     = 16'hAAAA;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_fall();
        if ({i2s_sclk, i2s_lrclk, i2s_sda} !== 3'b000)
            $display("FAIL drop_outputs: got %b want 000", {i2s_sclk, i2s_lrclk, i2s_sda});
        else passed++;
        total++;
        repeat (100) tick();
        if (fifo_level !== 3'd1) $display("FAIL drop_no_pop: got %0d want 1", fifo_level);
        else passed++;
        total++;
        if (i2s_sclk !== 1'b0) $display("FAIL drop_sclk_held: got %b want 0", i2s_sclk);
        else passed++;
        total++;
    endtask

    task automatic test_reset_midframe();
        int n;
        sample_valid = 1'b1;
        sample_l     = 16'hF00F;
        sample_r     = 16'h8181;
        repeat (2) tick();
        sample_valid = 1'b0;
        if (fifo_level !== 3'd3) $display("FAIL mid_level_pre: got %0d want 3", fifo_level);
        else passed++;
        total++;
        enable = 1'b1;
        wait_fall();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (3) wait_fall();
        n = 0;
        while (i2s_sclk !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (fifo_level !== 3'd3) $display("FAIL mid_level_queued: got %0d want 3", fifo_level);
        else passed++;
        total++;
        #2;
        rst_n = 1'b0;
        #1;
        if ({i2s_sclk, i2s_lrclk, i2s_sda} !== 3'b000)
            $display("FAIL mid_reset_outputs: got %b want 000", {i2s_sclk, i2s_lrclk, i2s_sda});
        else passed++;
        total++;
        if (fifo_level !== 3'd0) $display("FAIL mid_reset_level: got %0d want 0", fifo_level);
        else passed++;
        total++;
        if (sample_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", sample_ready);
        else passed++;
        total++;
        repeat (2) tick();
        rst_n = 1'b1;
        // Queued entries were discarded, so the first frame after reset underruns
        wait_fall();
        if (underrun !== 1'b1) $display("FAIL mid_post_underrun: got %b want 1", underrun);
        else passed++;
        total++;
        if (i2s_sda !== 1'b0) $display("FAIL mid_post_sda: got %b want 0", i2s_sda);
        else passed++;
        total++;
    endtask

    task automatic test_stability();
        repeat (3 * 32) wait_fall();
        if (glitches != 0) $display("FAIL sclk_rise_stability: got %0d changes want 0", glitches);
        else passed++;
        total++;
        if (timeouts != 0) $display("FAIL sclk_fall_timeout: got %0d timeouts want 0", timeouts);
        else passed++;
        total++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_underrun();
        test_back_to_back();
        test_enable_drop();
        test_reset_midframe();
        test_stability();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
